// File: rtl/alu.sv
// 16-bit registered ALU: the result and flags are computed combinationally from the
// current inputs and captured on every rising clock edge (one-cycle latency, no handshake).
module alu (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] input1,
    input  logic [15:0] input2,
    input  logic [4:0]  op,
    input  logic [4:0]  inFlags,
    output logic [15:0] result,
    output logic [4:0]  outFlags
);

    localparam logic [4:0] OP_ADD   = 5'd1;
    localparam logic [4:0] OP_ADDU  = 5'd2;
    localparam logic [4:0] OP_ADDC  = 5'd3;
    localparam logic [4:0] OP_ADDCU = 5'd4;
    localparam logic [4:0] OP_SUB   = 5'd5;
    localparam logic [4:0] OP_CMP   = 5'd6;
    localparam logic [4:0] OP_CMPU  = 5'd7;
    localparam logic [4:0] OP_AND   = 5'd8;
    localparam logic [4:0] OP_OR    = 5'd9;
    localparam logic [4:0] OP_XOR   = 5'd10;
    localparam logic [4:0] OP_NOT   = 5'd11;
    localparam logic [4:0] OP_LSH   = 5'd12;
    localparam logic [4:0] OP_RSH   = 5'd13;
    localparam logic [4:0] OP_ALSH  = 5'd14;
    localparam logic [4:0] OP_ARSH  = 5'd15;

    // Flag bit positions within outFlags
    localparam int FC = 0;
    localparam int FL = 1;
    localparam int FF = 2;
    localparam int FZ = 3;
    localparam int FN = 4;

    logic [15:0] result_q, result_d;
    logic [4:0]  flags_q, flags_d;

    logic [16:0] sum;
    logic [16:0] diff;
    logic        cin;
    logic        add_ovf;
    logic        sub_ovf;
    logic        signed_lt;
    logic        zn_valid;

    assign cin  = (op == OP_ADDC || op == OP_ADDCU) ? inFlags[0] : 1'b0;
    assign sum  = {1'b0, input1} + {1'b0, input2} + {16'd0, cin};
    // Bit 16 of the 17-bit difference is the unsigned borrow (A < B)
    assign diff = {1'b0, input1} - {1'b0, input2};

    assign add_ovf   = (input1[15] == input2[15]) && (sum[15] != input1[15]);
    assign sub_ovf   = (input1[15] != input2[15]) && (diff[15] != input1[15]);
    assign signed_lt = $signed(input1) < $signed(input2);

    always_comb begin
        result_d = 16'h0000;
        flags_d  = 5'b00000;
        zn_valid = 1'b1;
        unique case (op)
            OP_ADD, OP_ADDC: begin
                result_d    = sum[15:0];
                flags_d[FC] = sum[16];
                flags_d[FF] = add_ovf;
            end
            OP_ADDU, OP_ADDCU: begin
                result_d    = sum[15:0];
                flags_d[FC] = sum[16];
                flags_d[FF] = sum[16];
            end
            OP_SUB: begin
                result_d    = diff[15:0];
                flags_d[FC] = diff[16];
                flags_d[FF] = sub_ovf;
            end
            OP_CMP: begin
                zn_valid    = 1'b0;
                flags_d[FZ] = (input1 == input2);
                flags_d[FN] = signed_lt;
                flags_d[FL] = !signed_lt && (input1 != input2);
            end
            OP_CMPU: begin
                zn_valid    = 1'b0;
                flags_d[FZ] = (input1 == input2);
                flags_d[FN] = diff[16];
                flags_d[FL] = !diff[16] && (input1 != input2);
            end
            OP_AND:          result_d = input1 & input2;
            OP_OR:           result_d = input1 | input2;
            OP_XOR:          result_d = input1 ^ input2;
            OP_NOT:          result_d = ~input1;
            OP_LSH, OP_ALSH: result_d = {input1[14:0], 1'b0};
            OP_RSH:          result_d = {1'b0, input1[15:1]};
            OP_ARSH:         result_d = {input1[15], input1[15:1]};
            default:         zn_valid = 1'b0;
        endcase
        if (zn_valid) begin
            flags_d[FZ] = (result_d == 16'h0000);
            flags_d[FN] = result_d[15];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= 16'h0000;
            flags_q  <= 5'b00000;
        end else begin
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign result   = result_q;
    assign outFlags = flags_q;

endmodule

// File: tb/tb_alu.sv
// Directed vector bench for the registered ALU: table of hand-computed results and
// flags, plus reset sequences covering asynchronous clear and release.
module tb_alu;

    logic        clk;
    logic        reset;
    logic [15:0] input1;
    logic [15:0] input2;
    logic [4:0]  op;
    logic [4:0]  inFlags;
    logic [15:0] result;
    logic [4:0]  outFlags;

    int checks;
    int failures;

    typedef struct {
        logic [4:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [4:0]  fin;
        logic [15:0] exp_res;
        logic [4:0]  exp_flags;   // {N,Z,F,L,C}
    } vec_t;

    vec_t vq[$];

    alu dut (
        .clk      (clk),
        .reset    (reset),
        .input1   (input1),
        .input2   (input2),
        .op       (op),
        .inFlags  (inFlags),
        .result   (result),
        .outFlags (outFlags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] got_r, input logic [15:0] exp_r,
                         input logic [4:0] got_f, input logic [4:0] exp_f);
        checks++;
        if (got_r !== exp_r || got_f !== exp_f) begin
            failures++;
            $display("FAIL %s: result=%h flags=%b, expected result=%h flags=%b",
                     name, got_r, got_f, exp_r, exp_f);
        end
    endtask

    task automatic drive(input logic [4:0] o, input logic [15:0] a, input logic [15:0] b,
                         input logic [4:0] f);
        op      = o;
        input1  = a;
        input2  = b;
        inFlags = f;
    endtask

    task automatic add_vec(input logic [4:0] o, input logic [15:0] a, input logic [15:0] b,
                           input logic [4:0] f, input logic [15:0] r, input logic [4:0] fl);
        vec_t v;
        v.op = o; v.a = a; v.b = b; v.fin = f; v.exp_res = r; v.exp_flags = fl;
        vq.push_back(v);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        drive(5'd1, 16'd4, 16'd17, 5'b0);

        // Arithmetic
        add_vec(5'd1,  16'd4,      16'd17,    5'b0,     16'd21,    5'b00000);
        add_vec(5'd5,  16'd4,      16'd17,    5'b0,     16'hFFF3,  5'b10001);
        add_vec(5'd5,  16'd17,     16'd4,     5'b0,     16'd13,    5'b00000);
        add_vec(5'd2,  16'hFFFF,   16'd1,     5'b0,     16'h0000,  5'b01101);
        add_vec(5'd4,  16'hFFFF,   16'd1,     5'b00001, 16'h0001,  5'b00101);
        add_vec(5'd1,  16'h7FFF,   16'd1,     5'b0,     16'h8000,  5'b10100);
        add_vec(5'd1,  16'hFFFF,   16'hFFFF,  5'b11110, 16'hFFFE,  5'b10001);
        add_vec(5'd3,  16'h7FFF,   16'd0,     5'b00001, 16'h8000,  5'b10100);
        add_vec(5'd3,  16'h7FFF,   16'd0,     5'b11110, 16'h7FFF,  5'b00000);
        add_vec(5'd4,  16'hFFFF,   16'd1,     5'b11110, 16'h0000,  5'b01101);
        add_vec(5'd5,  16'h8000,   16'd1,     5'b0,     16'h7FFF,  5'b00100);
        add_vec(5'd5,  16'd9,      16'd9,     5'b0,     16'h0000,  5'b01000);
        // Compare
        add_vec(5'd6,  16'd17,     16'd4,     5'b0,     16'h0000,  5'b00010);
        add_vec(5'd6,  16'd17,     16'd17,    5'b0,     16'h0000,  5'b01000);
        add_vec(5'd6,  16'hFFFF,   16'd1,     5'b0,     16'h0000,  5'b10000);
        add_vec(5'd7,  16'hFFFF,   16'd1,     5'b0,     16'h0000,  5'b00010);
        add_vec(5'd7,  16'd1,      16'hFFFF,  5'b0,     16'h0000,  5'b10000);
        // Logic and shifts
        add_vec(5'd8,  16'd5,      16'd1,     5'b0,     16'd1,     5'b00000);
        add_vec(5'd9,  16'd5,      16'd2,     5'b0,     16'd7,     5'b00000);
        add_vec(5'd10, 16'd13,     16'd11,    5'b0,     16'd6,     5'b00000);
        add_vec(5'd11, 16'd60535,  16'hAAAA,  5'b0,     16'h1388,  5'b00000);
        add_vec(5'd8,  16'hF0F0,   16'h0F0F,  5'b0,     16'h0000,  5'b01000);
        add_vec(5'd11, 16'h0000,   16'h0000,  5'b0,     16'hFFFF,  5'b10000);
        add_vec(5'd12, 16'd69,     16'hFFFF,  5'b0,     16'd138,   5'b00000);
        add_vec(5'd14, 16'd69,     16'h1234,  5'b0,     16'd138,   5'b00000);
        add_vec(5'd13, 16'd69,     16'h0000,  5'b0,     16'd34,    5'b00000);
        add_vec(5'd15, 16'h8045,   16'h0000,  5'b0,     16'hC022,  5'b10000);
        add_vec(5'd13, 16'h8045,   16'h0000,  5'b0,     16'h4022,  5'b00000);
        add_vec(5'd12, 16'h8000,   16'h0000,  5'b0,     16'h0000,  5'b01000);
        add_vec(5'd12, 16'h4001,   16'h0000,  5'b0,     16'h8002,  5'b10000);
        // NOPs
        add_vec(5'd0,  16'hFFFF,   16'hFFFF,  5'b11111, 16'h0000,  5'b00000);
        add_vec(5'd16, 16'h1234,   16'h5678,  5'b11111, 16'h0000,  5'b00000);
        add_vec(5'd31, 16'h8000,   16'h8000,  5'b00001, 16'h0000,  5'b00000);

        // Reset state, including across a clock edge
        #2;
        check("reset_initial", result, 16'h0000, outFlags, 5'b00000);
        @(posedge clk); #1;
        check("reset_held_edge", result, 16'h0000, outFlags, 5'b00000);

        // Release: the first edge captures the then-current inputs
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("first_edge_after_release", result, 16'd21, outFlags, 5'b00000);

        // Back-to-back vectors, one per cycle
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            drive(vq[i].op, vq[i].a, vq[i].b, vq[i].fin);
            @(posedge clk); #1;
            check($sformatf("vec%0d_op%0d", i, vq[i].op), result, vq[i].exp_res,
                  outFlags, vq[i].exp_flags);
        end

        // Async reset between edges while outputs are nonzero
        @(negedge clk);
        drive(5'd2, 16'hFFFF, 16'd1, 5'b0);
        @(posedge clk); #1;
        check("pre_reset_nonzero", result, 16'h0000, outFlags, 5'b01101);
        @(negedge clk);
        drive(5'd1, 16'h7FFF, 16'd1, 5'b0);
        #1;
        check("pre_reset_hold", result, 16'h0000, outFlags, 5'b01101);
        reset = 1'b1;
        #1;
        check("async_reset_immediate", result, 16'h0000, outFlags, 5'b00000);
        @(posedge clk); #1;
        check("async_reset_held", result, 16'h0000, outFlags, 5'b00000);
        @(negedge clk);
        reset = 1'b0;
        drive(5'd10, 16'd13, 16'd11, 5'b0);
        #1;
        check("released_before_edge", result, 16'h0000, outFlags, 5'b00000);
        @(posedge clk); #1;
        check("after_midstream_reset", result, 16'd6, outFlags, 5'b00000);

        // Short reset pulse between edges discards the pending op
        @(negedge clk);
        drive(5'd1, 16'h7FFF, 16'd1, 5'b0);
        #1;
        reset = 1'b1;
        #1;
        check("pulse_reset_clear", result, 16'h0000, outFlags, 5'b00000);
        reset = 1'b0;
        drive(5'd9, 16'd5, 16'd2, 5'b0);
        @(posedge clk); #1;
        check("after_pulse_reset", result, 16'd7, outFlags, 5'b00000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001: clk  input  1  sole clock; all outputs update on its rising edge.
REQ-002: reset  input  1  asynchronous, active-high; clears all registered outputs immediately.
REQ-003: input1  input  16  operand A; the only operand for unary and shift ops.
REQ-004: input2  input  16  operand B.
REQ-005: op  input  5  operation select, see Function.
REQ-006: inFlags  input  5  previous flags; only bit 0 (carry-in) is used, by op 3/4.
REQ-007: result  output  16  registered operation result.
REQ-008: outFlags  output  5  registered flags; bit0 C carry/borrow, bit1 L greater-than, bit2 F overflow, bit3 Z zero/equal, bit4 N negative/less-than.

Function
REQ-009: The ALU SHALL compute result/flags combinationally from current inputs and register them on each rising clk edge; latency is exactly 1 cycle, with a new operation accepted every cycle (no handshake).
REQ-010: Opcodes SHALL be: 1 ADD signed, 2 ADDU unsigned, 3 ADDC signed A+B+inFlags[0], 4 ADDCU unsigned A+B+inFlags[0], 5 SUB signed A-B, 6 CMP signed, 7 CMPU unsigned, 8 AND, 9 OR, 10 XOR, 11 NOT A, 12 LSH A<<1, 13 RSH logical A>>1, 14 ALSH A<<<1, 15 ARSH arithmetic A>>>1 (bit15 replicated).
REQ-011: All arithmetic SHALL be 16-bit modulo, wrapping on overflow; the carry is taken from bit 16 of the 17-bit sum.
REQ-012: ADD/ADDC/SUB SHALL set F on two's-complement signed overflow; ADDU/ADDCU SHALL set both F and C on unsigned carry-out; ADD/ADDC SHALL set C on carry-out; SUB SHALL set C on borrow (A<B unsigned).
REQ-013: CMP/CMPU SHALL leave result at 0 and set L=1 iff A>B, Z=1 iff A==B, N=1 iff A<B (signed for 6, unsigned for 7); C=F=0.
REQ-014: For ops 1-5 and 8-15, Z SHALL be 1 iff result==0 and N SHALL equal result[15].
REQ-015: For ops 8-15, C, L and F SHALL be 0; LSH and ALSH produce identical results; shift amount is always 1; input2 is ignored for ops 11-15.
REQ-016: Any flag not defined for an op SHALL be 0.
REQ-017: Op 0 and ops 16-31 SHALL be NOPs: result=0, outFlags=0.
REQ-018: When inFlags[0]=0, ADDC/ADDCU SHALL behave identically to ADD/ADDU.

Reset
REQ-019: While reset=1, result SHALL be 16'h0000 and outFlags 5'b00000, regardless of clk.
REQ-020: Deasserting reset SHALL cause the first rising clk edge to capture the then-current inputs; no other state exists.
REQ-021: Asserting reset mid-stream SHALL discard the pending computation with no residual effect.

Verification
REQ-022: op=1, A=4, B=17 -> result 21 one cycle later, flags 0; op=5, A=4, B=17 -> result 16'hFFF3 (-13), N=1, C=1; A=17, B=4 -> 13.
REQ-023: op=2, A=65535, B=1 -> result 0, C=1, F=1, Z=1; op=4 same operands with inFlags[0]=1 -> result 1, C=1, F=1; op=1, A=16'h7FFF, B=1 -> 16'h8000, F=1, N=1.
REQ-024: op=6, A=17, B=4 -> L=1, Z=0; A=B=17 -> Z=1, L=0; op=6, A=16'hFFFF, B=1 -> N=1, L=0; op=7 with same operands -> L=1, N=0.
REQ-025: op=8 on 5,1 -> 1; op=9 on 5,2 -> 7; op=10 on 13,11 -> 6; op=11 on 60535 -> 16'h1388.
REQ-026: A=69: op=12 and op=14 -> 138, op=13 -> 34; A=16'h8045: op=15 -> 16'hC022, op=13 -> 16'h4022.
REQ-027: Assert reset between clk edges while outputs are nonzero -> outputs go to 0 immediately and stay 0 until the first edge after release.
